// File: rtl/move_sort_sequencer_pkg.sv
// Shared types and defaults for the move_sort pass sequencer.
package move_sort_sequencer_pkg;

  // Move word width; must match the RAM_WIDTH of the attached move_sort.
  localparam int RAM_WIDTH_DEF      = 16;
  localparam int TIMEOUT_DEF        = 4096;
  localparam int MAX_POSITIONS_DEF  = 256;

  typedef enum logic [3:0] {
    S_RESET_HOLD,
    S_IDLE,
    S_ARM,
    S_FILL,
    S_KICK,
    S_SORT_WAIT,
    S_DONE,
    S_DRAIN,
    S_DONE_NOSORT,
    S_ABORT
  } seq_state_t;

  // Count must be able to hold MAX_POSITIONS itself, hence the extra bit.
  function automatic int cnt_width(input int max_pos);
    return $clog2(max_pos) + 1;
  endfunction

endpackage

// File: rtl/move_sort_sequencer_if.sv
// Host, generator-stream and move_sort signals of the sequencer.
interface move_sort_sequencer_if
  import move_sort_sequencer_pkg::*;
#(
  parameter int RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int CNT_W     = cnt_width(MAX_POSITIONS_DEF)
);
  // host side
  logic                 host_start;
  logic                 host_white_to_move;
  logic                 host_ack;
  logic                 host_abort;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     move_count;
  logic                 err_overflow;
  logic                 err_timeout;
  // generator stream
  logic                 gen_valid;
  logic                 gen_ready;
  logic [RAM_WIDTH-1:0] gen_data;
  logic                 gen_last;
  logic                 gen_empty;
  // move_sort control
  logic                 sort_evaluate_go;
  logic                 sort_white_to_move;
  logic                 sort_wr_addr_init;
  logic                 sort_wr;
  logic [RAM_WIDTH-1:0] sort_wr_data;
  logic                 sort_start;
  logic                 sort_clear;
  logic                 sort_reset;
  logic                 sort_complete;

  modport master (
    input  host_start, host_white_to_move, host_ack, host_abort,
           gen_valid, gen_data, gen_last, gen_empty, sort_complete,
    output busy, done, move_count, err_overflow, err_timeout, gen_ready,
           sort_evaluate_go, sort_white_to_move, sort_wr_addr_init, sort_wr,
           sort_wr_data, sort_start, sort_clear, sort_reset
  );

  modport slave (
    output host_start, host_white_to_move, host_ack, host_abort,
           gen_valid, gen_data, gen_last, gen_empty, sort_complete,
    input  busy, done, move_count, err_overflow, err_timeout, gen_ready,
           sort_evaluate_go, sort_white_to_move, sort_wr_addr_init, sort_wr,
           sort_wr_data, sort_start, sort_clear, sort_reset
  );
endinterface

// File: rtl/move_sort_sequencer_sort_watchdog.sv
// Loadable down-counter guarding the sort phase; expires after
// TIMEOUT_CYCLES enabled cycles following a load.
module sort_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Count down while enabled; parks at zero so it fires only once per load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_cnt <= '0;
    else if (i_load)                 r_cnt <= CW'(TIMEOUT_CYCLES);
    else if (i_en && r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  // Fires in the last enabled cycle of the budget.
  assign o_expire = i_en && (r_cnt == CW'(1));
endmodule

// File: rtl/move_sort_sequencer.sv
// Sequences one move_sort pass: arm, stream moves in, sort, hand the result
// to the host, clear. Also guards move_sort against empty lists, overflow
// and stalled sorts.
module move_sort_sequencer
  import move_sort_sequencer_pkg::*;
#(
  parameter int RAM_WIDTH      = RAM_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int MAX_POSITIONS  = MAX_POSITIONS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  move_sort_sequencer_if.master bus
);
  localparam int CNT_W = cnt_width(MAX_POSITIONS);

  seq_state_t           r_state;
  logic                 r_hold, r_flush;
  logic                 r_busy, r_done, r_ovf, r_tmo, r_gen_ready;
  logic                 r_eval_go, r_side, r_addr_init, r_wr;
  logic                 r_start, r_clear, r_sreset;
  logic [CNT_W-1:0]     r_cnt;
  logic [RAM_WIDTH-1:0] r_wr_data;

  logic w_accept, w_end_beat, w_abort, w_flush_req;
  logic w_wd_load, w_wd_en, w_wd_expire;

  assign w_accept   = bus.gen_valid & r_gen_ready;
  assign w_end_beat = w_accept & (bus.gen_last | bus.gen_empty);
  assign w_abort    = bus.host_abort & (r_state != S_IDLE) &
                      (r_state != S_RESET_HOLD) & (r_state != S_ABORT);
  // Flush the generator only if its list for this pass is still in flight;
  // a last beat taken in the abort cycle itself already closes it.
  assign w_flush_req = (r_state == S_ARM) |
                       ((r_state == S_FILL) & ~(w_accept & bus.gen_last));
  assign w_wd_load  = (r_state == S_KICK);
  assign w_wd_en    = (r_state == S_SORT_WAIT);

  sort_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_wd_load),
    .i_en     (w_wd_en),
    .o_expire (w_wd_expire)
  );

  // Pass sequencer; every output is a register set here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RESET_HOLD;
      r_hold      <= 1'b0;
      r_flush     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_tmo       <= 1'b0;
      r_gen_ready <= 1'b0;
      r_eval_go   <= 1'b0;
      r_side      <= 1'b0;
      r_addr_init <= 1'b0;
      r_wr        <= 1'b0;
      r_start     <= 1'b0;
      r_clear     <= 1'b0;
      r_sreset    <= 1'b1;
      r_cnt       <= '0;
      r_wr_data   <= '0;
    end else begin
      r_eval_go   <= 1'b0;
      r_addr_init <= 1'b0;
      r_wr        <= 1'b0;
      r_start     <= 1'b0;
      r_clear     <= 1'b0;
      if (w_abort) begin
        r_state     <= S_ABORT;
        r_sreset    <= 1'b1;
        r_hold      <= 1'b0;
        r_flush     <= w_flush_req;
        r_gen_ready <= w_flush_req;
        r_done      <= 1'b0;
      end else begin
        case (r_state)
          S_RESET_HOLD: begin
            if (!r_hold) r_hold <= 1'b1;
            else begin
              r_hold   <= 1'b0;
              r_sreset <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
          S_IDLE: begin
            if (bus.host_start) begin
              r_side      <= bus.host_white_to_move;
              r_cnt       <= '0;
              r_ovf       <= 1'b0;
              r_tmo       <= 1'b0;
              r_done      <= 1'b0;
              r_addr_init <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_ARM;
            end
          end
          S_ARM: begin
            if (bus.gen_valid) begin
              // Ready rises next cycle to take this same beat.
              r_gen_ready <= 1'b1;
              if (bus.gen_empty) begin
                r_done  <= 1'b1;
                r_state <= S_DONE_NOSORT;
              end else begin
                r_eval_go <= 1'b1;
                r_state   <= S_FILL;
              end
            end
          end
          S_FILL: begin
            if (w_accept) begin
              if (r_cnt < CNT_W'(MAX_POSITIONS)) begin
                r_wr      <= 1'b1;
                r_wr_data <= bus.gen_data;
                r_cnt     <= r_cnt + 1'b1;
              end else begin
                r_ovf <= 1'b1;
              end
              if (bus.gen_last) begin
                r_gen_ready <= 1'b0;
                r_state     <= S_KICK;
              end
            end
          end
          S_KICK: begin
            r_start <= 1'b1;
            r_state <= S_SORT_WAIT;
          end
          S_SORT_WAIT: begin
            if (bus.sort_complete) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_wd_expire) begin
              // Stalled sort: report it, then reset move_sort.
              r_tmo    <= 1'b1;
              r_done   <= 1'b1;
              r_sreset <= 1'b1;
              r_hold   <= 1'b0;
              r_flush  <= 1'b0;
              r_state  <= S_ABORT;
            end
          end
          S_DONE: begin
            if (bus.host_ack) begin
              r_clear <= 1'b1;
              r_done  <= 1'b0;
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (!bus.sort_complete) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          S_DONE_NOSORT: begin
            r_gen_ready <= 1'b0;
            if (bus.host_ack) begin
              r_done  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          S_ABORT: begin
            // sort_reset spans two cycles; leave once the flush has closed too.
            if (w_end_beat) begin
              r_flush     <= 1'b0;
              r_gen_ready <= 1'b0;
            end
            if (!r_hold) r_hold <= 1'b1;
            else begin
              r_sreset <= 1'b0;
              if (!r_flush || w_end_beat) begin
                r_hold  <= 1'b0;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy               = r_busy;
  assign bus.done               = r_done;
  assign bus.move_count         = r_cnt;
  assign bus.err_overflow       = r_ovf;
  assign bus.err_timeout        = r_tmo;
  assign bus.gen_ready          = r_gen_ready;
  assign bus.sort_evaluate_go   = r_eval_go;
  assign bus.sort_white_to_move = r_side;
  assign bus.sort_wr_addr_init  = r_addr_init;
  assign bus.sort_wr            = r_wr;
  assign bus.sort_wr_data       = r_wr_data;
  assign bus.sort_start         = r_start;
  assign bus.sort_clear         = r_clear;
  assign bus.sort_reset         = r_sreset;
endmodule

// File: tb/tb_move_sort_sequencer.sv
// Directed bench for move_sort_sequencer: normal pass, empty list, overflow,
// sort timeout, host abort mid-fill, and reset during a sort.
module tb_move_sort_sequencer;
  import move_sort_sequencer_pkg::*;

  localparam int RW   = 16;
  localparam int TMO  = 16;
  localparam int MAXP = 8;
  localparam int CW   = cnt_width(MAXP);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  move_sort_sequencer_if #(.RAM_WIDTH(RW), .CNT_W(CW)) bus();

  move_sort_sequencer #(
    .RAM_WIDTH      (RW),
    .TIMEOUT_CYCLES (TMO),
    .MAX_POSITIONS  (MAXP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // pulse/event monitor, sampled on the active edge
  bit          clr_mon = 1'b0;
  int          cyc = 0, n_wr = 0, n_eval = 0, n_start = 0, n_srst = 0, n_acc = 0;
  int          eval_cyc = 0, wr1_cyc = 0, start_cyc = 0, tmo_cyc = 0;
  bit          tmo_seen = 1'b0;
  logic [RW-1:0] wr_data0 = '0;

  // Count move_sort strobes and timestamp the interesting ones.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_mon) begin
      n_wr <= 0; n_eval <= 0; n_start <= 0; n_srst <= 0; n_acc <= 0;
      tmo_seen <= 1'b0;
    end else begin
      if (bus.sort_wr) begin
        n_wr <= n_wr + 1;
        if (n_wr == 0) begin
          wr1_cyc  <= cyc;
          wr_data0 <= bus.sort_wr_data;
        end
      end
      if (bus.sort_evaluate_go) begin n_eval <= n_eval + 1; eval_cyc <= cyc; end
      if (bus.sort_start) begin n_start <= n_start + 1; start_cyc <= cyc; end
      if (bus.sort_reset) n_srst <= n_srst + 1;
      if (bus.gen_valid && bus.gen_ready) n_acc <= n_acc + 1;
      if (bus.err_timeout && !tmo_seen) begin tmo_seen <= 1'b1; tmo_cyc <= cyc; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1; step(); clr_mon = 1'b0;
  endtask

  task automatic start(input bit side);
    bus.host_start = 1'b1; bus.host_white_to_move = side;
    step();
    bus.host_start = 1'b0;
  endtask

  task automatic ack();
    bus.host_ack = 1'b1; step(); bus.host_ack = 1'b0;
  endtask

  // Push n beats through the valid/ready handshake.
  task automatic send(input int n, input int base, input bit empty, input bit mark_last);
    for (int i = 0; i < n; i++) begin
      int t;
      bit acc;
      bus.gen_valid = 1'b1;
      bus.gen_data  = 16'(base + i);
      bus.gen_last  = mark_last && (i == n - 1);
      bus.gen_empty = empty;
      t = 0; acc = 1'b0;
      while (!acc && t < 50) begin acc = bus.gen_ready; step(); t++; end
      if (!acc) chk("gen_accept", 0, 1);
    end
    bus.gen_valid = 1'b0; bus.gen_last = 1'b0; bus.gen_empty = 1'b0;
  endtask

  task automatic wait_start();
    int t = 0;
    while (!bus.sort_start && t < 50) begin step(); t++; end
    chk("sort_start_seen", bus.sort_start, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.done && t < 50) begin step(); t++; end
    chk("done_seen", bus.done, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 50) begin step(); t++; end
    chk("back_idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    bus.host_start = 0; bus.host_white_to_move = 0; bus.host_ack = 0; bus.host_abort = 0;
    bus.gen_valid = 0; bus.gen_data = '0; bus.gen_last = 0; bus.gen_empty = 0;
    bus.sort_complete = 0;

    // reset state and 2-cycle sort_reset tail
    step(); step();
    chk("rst_sort_reset", bus.sort_reset, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_gen_ready", bus.gen_ready, 0);
    chk("rst_count", bus.move_count, 0);
    reset = 1'b1;
    step(); chk("rst_hold_1", bus.sort_reset, 1);
    step(); chk("rst_hold_end", bus.sort_reset, 0);

    // normal pass: 3 beats
    clear_mon();
    start(1'b1);
    chk("p1_busy", bus.busy, 1);
    chk("p1_addr_init", bus.sort_wr_addr_init, 1);
    send(3, 10, 1'b0, 1'b1);
    wait_start();
    bus.sort_complete = 1'b1;
    wait_done();
    chk("p1_count", bus.move_count, 3);
    chk("p1_eval_go", n_eval, 1);
    chk("p1_writes", n_wr, 3);
    chk("p1_eval_to_wr", wr1_cyc - eval_cyc, 1);
    chk("p1_wr_data0", wr_data0, 10);
    chk("p1_side", bus.sort_white_to_move, 1);
    bus.host_start = 1'b1; step(); bus.host_start = 1'b0;
    chk("p1_start_ignored_done", bus.done, 1);
    chk("p1_start_ignored_cnt", bus.move_count, 3);
    ack();
    chk("p1_clear", bus.sort_clear, 1);
    chk("p1_done_drop", bus.done, 0);
    bus.sort_complete = 1'b0;
    wait_idle();
    chk("p1_sort_starts", n_start, 1);

    // empty move list: move_sort never armed
    clear_mon();
    start(1'b0);
    send(1, 0, 1'b1, 1'b1);
    chk("e_done", bus.done, 1);
    chk("e_count", bus.move_count, 0);
    ack();
    chk("e_done_drop", bus.done, 0);
    chk("e_idle", bus.busy, 0);
    chk("e_no_eval", n_eval, 0);
    chk("e_no_wr", n_wr, 0);
    chk("e_no_start", n_start, 0);
    chk("e_beats", n_acc, 1);

    // overflow: MAXP+2 beats
    clear_mon();
    start(1'b1);
    send(MAXP + 2, 100, 1'b0, 1'b1);
    wait_start();
    bus.sort_complete = 1'b1;
    wait_done();
    chk("o_writes", n_wr, MAXP);
    chk("o_flag", bus.err_overflow, 1);
    chk("o_count", bus.move_count, MAXP);
    chk("o_sort_ran", n_start, 1);
    ack();
    bus.sort_complete = 1'b0;
    wait_idle();

    // sort timeout
    clear_mon();
    start(1'b0);
    chk("t_ovf_cleared", bus.err_overflow, 0);
    send(2, 50, 1'b0, 1'b1);
    wait_start();
    begin
      int t = 0;
      while (!bus.err_timeout && t < 40) begin step(); t++; end
    end
    wait_idle();
    chk("t_flag", bus.err_timeout, 1);
    chk("t_latency", tmo_cyc - start_cyc, TMO);
    chk("t_done", bus.done, 1);
    chk("t_sort_reset", n_srst, 2);

    // host abort mid-fill, then a clean pass
    clear_mon();
    start(1'b1);
    send(2, 20, 1'b0, 1'b0);
    bus.host_abort = 1'b1; step(); bus.host_abort = 1'b0;
    chk("a_sort_reset", bus.sort_reset, 1);
    chk("a_flush_ready", bus.gen_ready, 1);
    send(3, 22, 1'b0, 1'b1);
    wait_idle();
    chk("a_writes", n_wr, 2);
    chk("a_sort_reset_len", n_srst, 2);
    chk("a_beats", n_acc, 5);
    clear_mon();
    start(1'b0);
    send(4, 30, 1'b0, 1'b1);
    wait_start();
    bus.sort_complete = 1'b1;
    wait_done();
    chk("a2_count", bus.move_count, 4);
    chk("a2_writes", n_wr, 4);
    chk("a2_wr_data0", wr_data0, 30);
    ack();
    bus.sort_complete = 1'b0;
    wait_idle();

    // reset while waiting on the sort
    clear_mon();
    start(1'b1);
    send(1, 7, 1'b0, 1'b1);
    wait_start();
    step(); step();
    reset = 1'b0; #1;
    chk("r_busy", bus.busy, 0);
    chk("r_done", bus.done, 0);
    chk("r_sort_reset", bus.sort_reset, 1);
    chk("r_count", bus.move_count, 0);
    chk("r_side", bus.sort_white_to_move, 0);
    step();
    reset = 1'b1;
    step(); chk("r_hold_1", bus.sort_reset, 1);
    step(); chk("r_hold_end", bus.sort_reset, 0);
    start(1'b0);
    chk("r_start_ok", bus.busy, 1);
    send(1, 0, 1'b1, 1'b1);
    ack();
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
